// File: rtl/upb_tcam_update_ctrl_if.sv
// Command channel between a rule-update requester and the TCAM update controller.
interface upb_tcam_update_ctrl_if #(
  parameter int TCAM_DEPTH = 64,
  parameter int DATA_WIDTH = 16
);
  localparam int IW = $clog2(TCAM_DEPTH) + 1;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_op;
  logic [IW-1:0]         cmd_index;
  logic [127:0]          cmd_srl;
  logic [DATA_WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_index, cmd_srl, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_index, cmd_srl, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/upb_tcam_update_ctrl.sv
// Sequences TCAM entry install/remove: deactivate, program SRL words, settle,
// write result data, reactivate; keeps a shadow of the TCAM active bitmap.
module upb_tcam_update_ctrl #(
  parameter int TCAM_DEPTH    = 64,
  parameter int DATA_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 40
) (
  input  logic                    CLK,
  input  logic                    RST,
  upb_tcam_update_ctrl_if.slave   cmd,
  output logic                    wen,
  output logic [31:0]             waddr,
  output logic [31:0]             wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [TCAM_DEPTH-1:0]   active_shadow
);
  localparam int IW = $clog2(TCAM_DEPTH) + 1;
  localparam int NW = (TCAM_DEPTH + 31) / 32;
  localparam int PW = NW * 32;
  localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, DEACT, SRL, SETTLE, DATA, ACT, FIN} state_t;

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  wen_q, wen_d;
  logic [31:0]           waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [TCAM_DEPTH-1:0] shadow_q, shadow_d;
  logic                  op_q, op_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [127:0]          srl_q, srl_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [TW-1:0]         tmr_q, tmr_d;

  logic [31:0]           cmd_idx32, cur_idx32, sel_idx32;
  logic [31:0]           word_sel, bit_mask;
  logic [TCAM_DEPTH-1:0] ent_mask;
  logic [PW-1:0]         shadow_pad;

  // Bits beyond TCAM_DEPTH in the last word are padding and always read as 0.
  function automatic logic [31:0] shadow_word(input logic [PW-1:0] pad, input logic [31:0] widx);
    logic [31:0] r;
    r = '0;
    for (int w = 0; w < NW; w++)
      if (widx == 32'(w)) r = pad[32*w +: 32];
    return r;
  endfunction

  assign cmd_idx32  = 32'(cmd.cmd_index);
  assign cur_idx32  = 32'(idx_q);
  assign shadow_pad = PW'(shadow_q);

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    shadow_d  = shadow_q;
    op_d      = op_q;
    idx_d     = idx_q;
    srl_d     = srl_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    sel_idx32 = (state_q == IDLE) ? cmd_idx32 : cur_idx32;
    word_sel  = shadow_word(shadow_pad, sel_idx32 >> 5);
    bit_mask  = 32'(1) << sel_idx32[4:0];
    ent_mask  = TCAM_DEPTH'(1) << sel_idx32;

    case (state_q)
      IDLE: begin
        if (!ready_q) begin
          ready_d = 1'b1;
        end else if (cmd.cmd_valid) begin
          ready_d = 1'b0;
          op_d    = cmd.cmd_op;
          idx_d   = IW'(cmd.cmd_index);
          srl_d   = cmd.cmd_srl;
          data_d  = DATA_WIDTH'(cmd.cmd_data);
          if (cmd_idx32 >= 32'(TCAM_DEPTH)) begin
            err_d = 1'b1;
          end else begin
            state_d  = DEACT;
            busy_d   = 1'b1;
            wen_d    = 1'b1;
            waddr_d  = 32'h3000 + (sel_idx32 >> 5);
            wdata_d  = word_sel & ~bit_mask;
            shadow_d = shadow_q & ~ent_mask;
          end
        end
      end
      DEACT: begin
        if (op_q) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          state_d = SRL;
          cnt_d   = 2'd0;
          wen_d   = 1'b1;
          waddr_d = 32'h1000 + (cur_idx32 << 2);
          wdata_d = srl_q[31:0];
        end
      end
      SRL: begin
        if (cnt_q == 2'd3) begin
          state_d = SETTLE;
          tmr_d   = TW'(SETTLE_CYCLES - 1);
        end else begin
          cnt_d   = cnt_q + 2'd1;
          wen_d   = 1'b1;
          waddr_d = 32'h1000 + (cur_idx32 << 2) + 32'(cnt_d);
          wdata_d = srl_q[{cnt_d, 5'd0} +: 32];
        end
      end
      SETTLE: begin
        if (tmr_q == '0) begin
          state_d = DATA;
          wen_d   = 1'b1;
          waddr_d = 32'h2000 + cur_idx32;
          wdata_d = 32'(data_q);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      DATA: begin
        state_d  = ACT;
        wen_d    = 1'b1;
        waddr_d  = 32'h3000 + (cur_idx32 >> 5);
        wdata_d  = word_sel | bit_mask;
        shadow_d = shadow_q | ent_mask;
      end
      ACT: begin
        state_d = FIN;
        done_d  = 1'b1;
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset abandons any command; the TCAM clears its own active bits likewise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      shadow_q <= '0;
      op_q     <= 1'b0;
      idx_q    <= '0;
      srl_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      srl_q    <= srl_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
    end
  end

  assign cmd.cmd_ready   = ready_q;
  assign wen             = wen_q;
  assign waddr           = waddr_q;
  assign wdata           = wdata_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign active_shadow   = shadow_q;
endmodule

// File: tb/tb_upb_tcam_update_ctrl.sv
// Directed bench for upb_tcam_update_ctrl: cycle-exact install/remove/error/reset sequences.
module tb_upb_tcam_update_ctrl;
  localparam int S0 = 40;
  localparam int S1 = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  upb_tcam_update_ctrl_if #(.TCAM_DEPTH(64), .DATA_WIDTH(16)) bus0 ();
  upb_tcam_update_ctrl_if #(.TCAM_DEPTH(16), .DATA_WIDTH(16)) bus1 ();

  logic        wen0, busy0, done0, err0;
  logic [31:0] waddr0, wdata0;
  logic [63:0] sh0;
  logic        wen1, busy1, done1, err1;
  logic [31:0] waddr1, wdata1;
  logic [15:0] sh1;

  upb_tcam_update_ctrl #(.TCAM_DEPTH(64), .DATA_WIDTH(16), .SETTLE_CYCLES(S0)) dut0 (
    .CLK(CLK), .RST(RST), .cmd(bus0.slave), .wen(wen0), .waddr(waddr0), .wdata(wdata0),
    .busy(busy0), .done(done0), .err(err0), .active_shadow(sh0));

  upb_tcam_update_ctrl #(.TCAM_DEPTH(16), .DATA_WIDTH(16), .SETTLE_CYCLES(S1)) dut1 (
    .CLK(CLK), .RST(RST), .cmd(bus1.slave), .wen(wen1), .waddr(waddr1), .wdata(wdata1),
    .busy(busy1), .done(done1), .err(err1), .active_shadow(sh1));

  int errors = 0;
  int checks = 0;
  logic [31:0] last_addr0 = 32'h0;
  logic [31:0] last_wd0   = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Offers a command on DUT0 and returns sampled in cycle 1 with cmd_valid dropped.
  task automatic issue0(input logic op, input logic [6:0] idx, input logic [127:0] srl,
                        input logic [15:0] data, input logic keep_valid);
    chk("ready_before_issue", bus0.cmd_ready, 1);
    bus0.cmd_op    = op;
    bus0.cmd_index = idx;
    bus0.cmd_srl   = srl;
    bus0.cmd_data  = data;
    bus0.cmd_valid = 1'b1;
    tick();
    if (!keep_valid) bus0.cmd_valid = 1'b0;
  endtask

  // Called in cycle 1 of an install; returns sampled in cycle 9+S.
  task automatic check_install0(input int idx, input logic [31:0] deact_wd, input logic [31:0] act_wd,
                                input logic [127:0] srl, input logic [15:0] data);
    logic        ew;
    logic [31:0] ea, ed;
    for (int c = 1; c <= 9 + S0; c++) begin
      ew = 1'b1;
      ea = last_addr0;
      ed = last_wd0;
      if (c == 1) begin
        ea = 32'h3000 + 32'(idx / 32); ed = deact_wd;
      end else if (c >= 2 && c <= 5) begin
        ea = 32'h1000 + 32'(4 * idx + c - 2); ed = srl[32*(c-2) +: 32];
      end else if (c == 6 + S0) begin
        ea = 32'h2000 + 32'(idx); ed = {16'h0, data};
      end else if (c == 7 + S0) begin
        ea = 32'h3000 + 32'(idx / 32); ed = act_wd;
      end else begin
        ew = 1'b0;
      end
      chk($sformatf("inst%0d_wen_c%0d", idx, c), wen0, ew);
      chk($sformatf("inst%0d_waddr_c%0d", idx, c), waddr0, ea);
      chk($sformatf("inst%0d_wdata_c%0d", idx, c), wdata0, ed);
      chk($sformatf("inst%0d_done_c%0d", idx, c), done0, (c == 8 + S0));
      chk($sformatf("inst%0d_busy_c%0d", idx, c), busy0, (c <= 8 + S0));
      chk($sformatf("inst%0d_ready_c%0d", idx, c), bus0.cmd_ready, (c == 9 + S0));
      last_addr0 = ea;
      last_wd0   = ed;
      if (c < 9 + S0) tick();
    end
  endtask

  // Called in cycle 1 of a remove; returns sampled in cycle 3.
  task automatic check_remove0(input int idx, input logic [31:0] deact_wd);
    last_addr0 = 32'h3000 + 32'(idx / 32);
    last_wd0   = deact_wd;
    chk("rem_wen_c1", wen0, 1);
    chk("rem_waddr_c1", waddr0, last_addr0);
    chk("rem_wdata_c1", wdata0, last_wd0);
    chk("rem_busy_c1", busy0, 1);
    chk("rem_done_c1", done0, 0);
    tick();
    chk("rem_wen_c2", wen0, 0);
    chk("rem_done_c2", done0, 1);
    chk("rem_busy_c2", busy0, 1);
    chk("rem_ready_c2", bus0.cmd_ready, 0);
    chk("rem_waddr_hold_c2", waddr0, last_addr0);
    tick();
    chk("rem_ready_c3", bus0.cmd_ready, 1);
    chk("rem_done_c3", done0, 0);
    chk("rem_busy_c3", busy0, 0);
  endtask

  localparam logic [127:0] SRL_A = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
  localparam logic [127:0] SRL_B = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

  initial begin
    int wcount;
    bus0.cmd_valid = 1'b0; bus0.cmd_op = 1'b0; bus0.cmd_index = '0; bus0.cmd_srl = '0; bus0.cmd_data = '0;
    bus1.cmd_valid = 1'b0; bus1.cmd_op = 1'b0; bus1.cmd_index = '0; bus1.cmd_srl = '0; bus1.cmd_data = '0;

    // Reset state
    tick(); tick();
    chk("rst_ready", bus0.cmd_ready, 0);
    chk("rst_wen", wen0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_err", err0, 0);
    chk("rst_waddr", waddr0, 0);
    chk("rst_wdata", wdata0, 0);
    chk("rst_shadow", sh0, 0);
    RST = 1'b0;
    tick();
    chk("ready_after_rst", bus0.cmd_ready, 1);

    // Install idx 5
    issue0(1'b0, 7'd5, SRL_A, 16'h1234, 1'b0);
    check_install0(5, 32'h0, 32'h20, SRL_A, 16'h1234);
    chk("shadow_after_i5", sh0, 64'h20);

    // Install idx 37 with 5 active, then remove 5
    tick();
    issue0(1'b0, 7'd37, SRL_B, 16'hBEEF, 1'b0);
    check_install0(37, 32'h0, 32'h20, SRL_B, 16'hBEEF);
    chk("shadow_after_i37", sh0, 64'h0000_0020_0000_0020);
    tick();
    issue0(1'b1, 7'd5, '0, 16'h0, 1'b0);
    check_remove0(5, 32'h0);
    chk("shadow_after_r5", sh0, 64'h0000_0020_0000_0000);

    // Reinstall already-active 37: still deactivates first
    issue0(1'b0, 7'd37, SRL_A, 16'h0F0F, 1'b0);
    chk("reinst37_shadow_c1", sh0, 64'h0);
    check_install0(37, 32'h0, 32'h20, SRL_A, 16'h0F0F);
    chk("shadow_after_reinst37", sh0, 64'h0000_0020_0000_0000);

    // Remove inactive idx 9: still writes
    tick();
    issue0(1'b1, 7'd9, '0, 16'h0, 1'b0);
    check_remove0(9, 32'h0);
    chk("shadow_after_r9", sh0, 64'h0000_0020_0000_0000);

    // Out-of-range index
    issue0(1'b0, 7'd64, SRL_A, 16'h5555, 1'b0);
    chk("oor_err_c1", err0, 1);
    chk("oor_wen_c1", wen0, 0);
    chk("oor_done_c1", done0, 0);
    chk("oor_ready_c1", bus0.cmd_ready, 0);
    tick();
    chk("oor_ready_c2", bus0.cmd_ready, 1);
    chk("oor_err_c2", err0, 0);
    chk("oor_wen_c2", wen0, 0);
    chk("oor_done_c2", done0, 0);
    chk("oor_waddr_hold", waddr0, last_addr0);
    chk("oor_wdata_hold", wdata0, last_wd0);
    chk("oor_shadow", sh0, 64'h0000_0020_0000_0000);

    // cmd_valid held through an install; second command (remove 2) waits until 9+S
    issue0(1'b0, 7'd2, SRL_B, 16'h00A5, 1'b1);
    bus0.cmd_op = 1'b1;
    bus0.cmd_srl = '0;
    bus0.cmd_data = 16'h0;
    check_install0(2, 32'h0, 32'h4, SRL_B, 16'h00A5);
    chk("b2b_shadow_before_rem", sh0, 64'h0000_0020_0000_0004);
    tick();
    bus0.cmd_valid = 1'b0;
    check_remove0(2, 32'h0);
    chk("shadow_after_b2b", sh0, 64'h0000_0020_0000_0000);

    // Reset in SETTLE abandons the install
    issue0(1'b0, 7'd10, SRL_A, 16'h7777, 1'b0);
    for (int c = 1; c < 20; c++) tick();
    chk("mid_busy_c20", busy0, 1);
    chk("mid_wen_c20", wen0, 0);
    RST = 1'b1;
    tick();
    chk("mid_rst_shadow", sh0, 0);
    chk("mid_rst_ready", bus0.cmd_ready, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_waddr", waddr0, 0);
    tick();
    RST = 1'b0;
    tick();
    chk("mid_ready_after_rst", bus0.cmd_ready, 1);
    wcount = 0;
    for (int c = 0; c < 60; c++) begin
      if (wen0) wcount++;
      tick();
    end
    chk("mid_no_writes_after_rst", wcount, 0);
    chk("mid_shadow_final", sh0, 0);
    chk("mid_done_final", done0, 0);

    // DUT1: depth 16, install idx 15
    chk("d1_ready", bus1.cmd_ready, 1);
    bus1.cmd_op = 1'b0; bus1.cmd_index = 5'd15; bus1.cmd_srl = SRL_B; bus1.cmd_data = 16'hCAFE;
    bus1.cmd_valid = 1'b1;
    tick();
    bus1.cmd_valid = 1'b0;
    chk("d1_deact_wen", wen1, 1);
    chk("d1_deact_waddr", waddr1, 32'h3000);
    chk("d1_deact_wdata", wdata1, 32'h0);
    for (int c = 1; c < 6 + S1; c++) tick();
    chk("d1_data_wen", wen1, 1);
    chk("d1_data_waddr", waddr1, 32'h200F);
    chk("d1_data_wdata", wdata1, 32'h0000_CAFE);
    tick();
    chk("d1_act_wen", wen1, 1);
    chk("d1_act_waddr", waddr1, 32'h3000);
    chk("d1_act_wdata", wdata1, 32'h0000_8000);
    chk("d1_shadow", sh1, 16'h8000);
    tick();
    chk("d1_done", done1, 1);
    chk("d1_wen_fin", wen1, 0);
    tick();
    chk("d1_ready_after", bus1.cmd_ready, 1);

    // DUT1: idx 16 is out of range
    bus1.cmd_index = 5'd16;
    bus1.cmd_valid = 1'b1;
    tick();
    bus1.cmd_valid = 1'b0;
    chk("d1_oor_err", err1, 1);
    chk("d1_oor_wen", wen1, 0);
    chk("d1_oor_busy", busy1, 0);
    tick();
    chk("d1_oor_ready_c2", bus1.cmd_ready, 1);
    chk("d1_oor_shadow", sh1, 16'h8000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/upb_tcam_update_ctrl.md
UPB_TCAM_UPDATE_CTRL -- requirements
Module: upb_tcam_update_ctrl

Interface
REQ-001 Parameter TCAM_DEPTH, default 64, number of TCAM entries (1..1024).
REQ-002 Parameter DATA_WIDTH, default 16, width of the per-entry result data (max 32).
REQ-003 Parameter SETTLE_CYCLES, default 40, idle cycles after the last SRL write before the entry is reactivated (min 1).
REQ-004 CLK  in  1  clock; all logic on the rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid  in  1  a command is offered.
REQ-007 cmd_ready  out  1  controller accepts a command this cycle.
REQ-008 cmd_op  in  1  0 = install, 1 = remove.
REQ-009 cmd_index  in  $clog2(TCAM_DEPTH)+1  target entry index.
REQ-010 cmd_srl  in  128  SRL programming words; word w = cmd_srl[32*w+31 -: 32], w = 0..3.
REQ-011 cmd_data  in  DATA_WIDTH  result data for the entry.
REQ-012 wen / waddr / wdata  out  1 / 32 / 32  TCAM register write port.
REQ-013 busy  out  1  a command is in progress.
REQ-014 done  out  1  one-cycle pulse: command completed.
REQ-015 err  out  1  one-cycle pulse: command rejected.
REQ-016 active_shadow  out  TCAM_DEPTH  controller copy of the TCAM active bitmap.

Function
REQ-017 A command SHALL be accepted on a cycle with cmd_valid && cmd_ready; cmd_ready SHALL be 1 only in IDLE, and all cmd_* fields are captured on acceptance.
REQ-018 FSM states SHALL be IDLE, DEACT, SRL, SETTLE, DATA, ACT, FIN; all outputs are registered.
REQ-019 Install: IDLE -> DEACT (1 cyc) -> SRL (4 cyc, w = 0..3) -> SETTLE (SETTLE_CYCLES cyc) -> DATA (1 cyc) -> ACT (1 cyc) -> FIN (1 cyc) -> IDLE.
REQ-020 Remove: IDLE -> DEACT -> FIN -> IDLE.
REQ-021 Relative to the acceptance cycle 0, wen SHALL be high exactly in: install cycles 1, 2..5, 6+S, 7+S (S = SETTLE_CYCLES); remove cycle 1; wen is 0 in all other cycles.
REQ-022 DEACT write: waddr = 0x3000 + (index>>5); wdata = shadow word (index>>5) with bit index[4:0] cleared; the shadow bit is cleared in the same cycle.
REQ-023 SRL write w: waddr = 0x1000 + 4*index + w; wdata = cmd_srl word w.
REQ-024 DATA write: waddr = 0x2000 + index; wdata = cmd_data zero-extended to 32 bits.
REQ-025 ACT write: waddr = 0x3000 + (index>>5); wdata = shadow word with bit index[4:0] set; the shadow bit is set in the same cycle.
REQ-026 Shadow word bits at positions >= TCAM_DEPTH SHALL read and be written as 0.
REQ-027 done SHALL pulse in FIN (install cycle 8+S, remove cycle 2); cmd_ready SHALL return to 1 in the cycle after FIN.
REQ-028 busy SHALL be 1 from cycle 1 through FIN inclusive.
REQ-029 Install to an already-active entry SHALL still deactivate first; remove of an inactive entry SHALL still issue its DEACT write (idempotent).
REQ-030 cmd_index >= TCAM_DEPTH: no TCAM write; err pulses in cycle 1; done is not asserted; cmd_ready returns to 1 in cycle 2.
REQ-031 cmd_valid while busy SHALL be ignored; the command is held by the requester until cmd_ready.
REQ-032 waddr/wdata SHALL hold their last written value while wen = 0.

Reset
REQ-033 While RST: state = IDLE; wen, busy, done, err = 0; waddr, wdata = 0; active_shadow = 0; cmd_ready = 0; cmd_ready = 1 in the first cycle after RST deasserts.
REQ-034 RST mid-command SHALL abandon the command with no further writes; the shadow is cleared, matching the TCAM clearing its own active bits on reset.

Verification
REQ-035 Install idx 5, S=40, srl words A,B,C,D, data 0x1234 -> writes (0x3000,0x0), (0x1014..0x1017, A..D), (0x2005,0x1234) at cycle 46, (0x3000,0x20) at cycle 47, done at cycle 48.
REQ-036 Install idx 37 with 5 already active, then remove idx 5 -> ACT write (0x3001,0x20); remove DEACT (0x3000,0x0) at cycle 1, done at cycle 2, active_shadow = bit 37 only.
REQ-037 Index 64 with TCAM_DEPTH=64 -> no wen, err pulse at cycle 1, cmd_ready=1 at cycle 2.
REQ-038 cmd_valid held high through an install -> second command accepted only at cycle 9+S; no overlap of write sequences.
REQ-039 RST asserted in SETTLE of an install -> no DATA/ACT writes, active_shadow = 0, cmd_ready = 1 the cycle after RST drops.
REQ-040 TCAM_DEPTH=16, install idx 15 -> ACT wdata = 0x00008000, bits 16..31 are 0.
